preamble_frame_tx: RTL and testbench
====================================

// Module: preamble_frame_tx
// PURPOSE
//  Serial frame transmitter: emits a fixed preamble (default 1101), then a DATA_W-bit
//  payload MSB-first, then GAP_BITS idle zeros, one bit per bit_en strobe.
//  Transmit end of the 1101 overlap sequence-detector link; the receiver uses the
//  preamble to find frame start. Payload is not escaped; 1101 inside payload is legal.
// PARAMETERS
//  DATA_W    8        payload width in bits (>=1)
//  PRE_W     4        preamble width in bits (>=1)
//  PREAMBLE  4'b1101  preamble pattern, sent MSB first
//  GAP_BITS  2        idle bit slots after payload (>=0; 0 = no gap)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       async reset, active-high
//  bit_en     in   1       bit-slot strobe; serial state advances only when 1
//  in_valid   in   1       payload word offered
//  in_data    in   DATA_W  payload word
//  in_ready   out  1       block can accept a word (1 iff state IDLE)
//  out_bit    out  1       serial line, registered; 0 when not transmitting
//  out_valid  out  1       registered; 1 while a preamble/payload bit is on out_bit
//  busy       out  1       1 in any state other than IDLE
//  frame_done out  1       registered 1-cycle pulse after last payload bit slot
// BEHAVIOUR
//  Reset (async, any time, incl. mid-frame): state IDLE, counters 0, shift reg 0,
//   out_bit=0, out_valid=0, busy=0, frame_done=0, in_ready=1. Partial frame dropped.
//  States IDLE -> PRE -> DATA -> GAP -> IDLE (GAP skipped when GAP_BITS=0).
//  IDLE: accept when in_valid&&in_ready (bit_en not required); latch in_data; next
//   edge: PRE, bit index 0, out_bit=PREAMBLE[PRE_W-1], out_valid=1.
//  PRE: on each bit_en edge, advance index; after bit 0 of preamble shown and
//   bit_en=1 -> DATA, out_bit=in_data[DATA_W-1].
//  DATA: on each bit_en edge shift next lower bit; after bit 0 shown and bit_en=1:
//   frame_done=1 for that next cycle; out_valid=0, out_bit=0; go GAP (or IDLE).
//  GAP: out_bit=0, out_valid=0; count GAP_BITS bit_en strobes, then IDLE.
//  bit_en=0: all outputs and counters hold (frame_done still only 1 cycle).
//  Each bit held on out_bit for exactly one bit_en-qualified cycle (bit slot).
//  in_valid while busy: ignored, word not consumed; in_data sampled only at accept.
//  Latency, bit_en tied 1: accept edge T -> bits on cycles T+1..T+PRE_W+DATA_W,
//   in_ready high again at T+1+PRE_W+DATA_W+GAP_BITS.
//  Back-to-back: with GAP_BITS=0 next accept may occur on first IDLE cycle; no
//   overlap of frames, no dropped bits.
//  Counters sized $clog2(max(PRE_W,DATA_W,GAP_BITS)+1); no wrap within a frame.
// TESTING
//  1 Reset asserted -> out_bit=0,out_valid=0,busy=0,frame_done=0,in_ready=1.
//  2 bit_en=1, in_data=8'hA5 -> out_bit 1,1,0,1,1,0,1,0,0,1,0,1 on cycles T+1..T+12,
//    out_valid=1 there; frame_done=1 only at T+13; out 0 T+13..T+14; in_ready=1 at T+15.
//  3 bit_en=1 every 3rd cycle, in_data=8'h0F -> each bit held 3 cycles, same bit
//    order 1101_00001111, frame_done exactly one cycle wide.
//  4 reset pulsed while in DATA bit 3 -> outputs to reset values same cycle; next
//    accept of 8'h3C produces full fresh preamble+payload.
//  5 in_valid held high with alternating 8'hFF/8'h00 words -> each word accepted
//    only when in_ready=1, frames emitted in order, gaps of 2 zero slots between.
//  6 Loopback into 1101 overlap detector (reset inverted), in_data=8'h00 ->
//    exactly one detect, in cycle after last preamble bit slot.

Source files
------------

// File: rtl/preamble_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle gap slots.
// The serial line only advances on bit_en strobes. A new word is accepted only in IDLE.
module preamble_frame_tx #(
    parameter int                 DATA_W   = 8,
    parameter int                 PRE_W    = 4,
    parameter logic [PRE_W-1:0]   PREAMBLE = 4'b1101,
    parameter int                 GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int FW    = PRE_W + DATA_W;
    localparam int MAX_A = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAXV  = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
    localparam int CW    = $clog2(MAXV + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_W - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] sr_q, sr_d;
    logic          out_bit_q, out_bit_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;

    logic [FW-1:0] sr_loaded;
    logic [FW-1:0] sr_shifted;

    // Preamble and payload share one shift register; its MSB is always the next line bit.
    assign sr_loaded  = {PREAMBLE, in_data};
    assign sr_shifted = sr_q << 1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d     = S_PRE;
                    cnt_d       = '0;
                    sr_d        = sr_loaded;
                    out_bit_d   = sr_loaded[FW-1];
                    out_valid_d = 1'b1;
                end
            end
            S_PRE: begin
                if (bit_en) begin
                    sr_d      = sr_shifted;
                    out_bit_d = sr_shifted[FW-1];
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_DATA: begin
                if (bit_en) begin
                    if (cnt_q == DATA_LAST) begin
                        state_d     = (GAP_BITS > 0) ? S_GAP : S_IDLE;
                        cnt_d       = '0;
                        sr_d        = '0;
                        out_bit_d   = 1'b0;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        sr_d      = sr_shifted;
                        out_bit_d = sr_shifted[FW-1];
                        cnt_d     = cnt_q + CNT_ONE;
                    end
                end
            end
            S_GAP: begin
                if (bit_en) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                sr_d        = '0;
                out_bit_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_preamble_frame_tx.sv
// Randomized scoreboard bench for preamble_frame_tx, checked against a bit-slot reference model.
// The model counts remaining bit slots per frame; a queue holds the expected line bits.
module tb_preamble_frame_tx;

    localparam int DATA_W = 8;
    localparam int PRE_W  = 4;
    localparam int GAP    = 2;
    localparam int FW     = PRE_W + DATA_W;
    localparam int TOT    = FW + GAP;

    logic              clk;
    logic              reset;
    logic              bit_en;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_bit;
    logic              out_valid;
    logic              busy;
    logic              frame_done;

    preamble_frame_tx #(
        .DATA_W(DATA_W), .PRE_W(PRE_W), .PREAMBLE(4'b1101), .GAP_BITS(GAP)
    ) dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .busy(busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is TOT bit slots; the first FW are the line bits.
    logic [PRE_W-1:0] pre_pat = 4'b1101;
    int               rem = 0;
    logic [FW-1:0]    frame_m = '0;
    logic             fd_exp = 1'b0;
    logic             acc_pulse = 1'b0;
    logic             exp_q[$];
    int               frames = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem       = 0;
            fd_exp    = 1'b0;
            acc_pulse = 1'b0;
            exp_q.delete();
        end else begin
            fd_exp    = 1'b0;
            acc_pulse = 1'b0;
            if (rem == 0) begin
                if (in_valid) begin
                    rem       = TOT;
                    frame_m   = {pre_pat, in_data};
                    acc_pulse = 1'b1;
                    frames++;
                    for (int i = FW - 1; i >= 0; i--) exp_q.push_back(frame_m[i]);
                    $display("accept frame %0d data=%02h", frames, in_data);
                end
            end else if (bit_en) begin
                if (rem == GAP + 1) fd_exp = 1'b1;
                rem--;
            end
        end
    end

    // Monitor plus a behavioural loopback 1101 overlap detector on bit slots.
    logic [3:0] hist = 4'b0;
    int         det_cnt = 0;
    int         det_slot = -1;

    always @(negedge clk) begin
        if (!reset) begin
            automatic int   slot  = TOT - rem;
            automatic logic exp_v = (rem > GAP);
            chk("in_ready", in_ready, rem == 0);
            chk("busy", busy, rem != 0);
            chk("out_valid", out_valid, exp_v);
            chk("frame_done", frame_done, fd_exp);
            chk("out_bit", out_bit, exp_v ? frame_m[FW-1-slot] : 1'b0);
            if (out_valid && bit_en) begin
                if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
                else chk("sb_bit", out_bit, exp_q.pop_front());
            end
            if (bit_en) begin
                hist = {hist[2:0], out_bit};
                if (hist == 4'b1101) begin
                    det_cnt++;
                    det_slot = slot;
                end
            end
        end
    end

    // Bit strobe generator: 0 = every cycle, 1 = every 3rd cycle, 2 = random.
    int be_mode = 0;
    int be_ph = 0;
    always @(posedge clk) begin
        #2;
        case (be_mode)
            0: bit_en = 1'b1;
            1: begin
                bit_en = (be_ph == 2);
                be_ph  = (be_ph + 1) % 3;
            end
            default: bit_en = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (rem != 0 && n < 4000);
        if (rem != 0) begin
            checks++;
            $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        wait_idle();
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_bit"}, out_bit, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        reset    = 1'b1;
        bit_en   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(posedge clk); #2;
        reset = 1'b0;

        // Nominal frame, then a slow strobe frame.
        send_word(8'hA5);
        wait_idle();
        be_mode = 1;
        send_word(8'h0F);
        wait_idle();

        // Reset while payload bit 3 is on the line.
        be_mode = 0;
        send_word(8'h96);
        begin
            int n = 0;
            while (rem != TOT - (PRE_W + DATA_W - 1 - 3) && n < 100) begin
                @(posedge clk); #2;
                n++;
            end
        end
        chk("reached_data_bit3", out_valid, 1);
        #1 reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        @(posedge clk); #2;
        reset = 1'b0;
        $display("mid-frame reset applied, frame dropped");
        send_word(8'h3C);
        wait_idle();

        // in_valid held high with alternating words.
        begin
            int n = 0;
            int cyc = 0;
            in_valid = 1'b1;
            in_data  = 8'hFF;
            while (n < 4 && cyc < 500) begin
                @(posedge clk); #2;
                cyc++;
                if (acc_pulse) begin
                    n++;
                    in_data = (n % 2 == 1) ? 8'h00 : 8'hFF;
                end
            end
            in_valid = 1'b0;
            chk("held_valid_accepts", n, 4);
        end
        wait_idle();

        // Loopback detection of a zero payload frame.
        hist     = 4'b0;
        det_cnt  = 0;
        det_slot = -1;
        send_word(8'h00);
        wait_idle();
        chk("detect_count", det_cnt, 1);
        chk("detect_slot", det_slot, PRE_W - 1);

        // Random strobes, random words, spurious in_valid while busy.
        be_mode = 2;
        for (int f = 0; f < 20; f++) begin
            send_word(DATA_W'($urandom));
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #2;
                if (rem != 0 && $urandom_range(0, 3) == 0) begin
                    in_valid = 1'b1;
                    in_data  = DATA_W'($urandom);
                    @(posedge clk); #2;
                    in_valid = 1'b0;
                end
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
